// File: rtl/ca_1d_stepper.sv
// One-dimensional binary cellular automaton of radius RADIUS. It applies one
// generation per clock for a programmed number of steps and stops early if the state reaches a fixed point.
module ca_1d_stepper #(
    parameter int              WIDTH  = 16,
    parameter int              RADIUS = 1,
    parameter int              STEP_W = 16,
    parameter logic [WIDTH-1:0] INIT  = {(WIDTH/2){2'b01}},
    localparam int             NBR_W  = 2*RADIUS+1,
    localparam int             RULE_W = 2**NBR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RULE_W-1:0] rule_i,
    input  logic [1:0]        bmode_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_data_i,
    input  logic              start_i,
    input  logic [STEP_W-1:0] steps_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fixed_pt_o,
    output logic [STEP_W-1:0] gen_count_o,
    output logic [WIDTH-1:0]  state_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_e;

    typedef enum logic [1:0] {
        BM_WRAP   = 2'd0,
        BM_ZERO   = 2'd1,
        BM_ONE    = 2'd2,
        BM_MIRROR = 2'd3
    } bmode_e;

    fsm_e              fsm_q, fsm_d;
    logic [WIDTH-1:0]  state_q, state_d;
    logic [RULE_W-1:0] rule_q, rule_d;
    bmode_e            bmode_q, bmode_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [STEP_W-1:0] gen_q, gen_d;
    logic              done_q, done_d;
    logic              fixed_q, fixed_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  next_state_s;

    // Value of neighbour position j, resolving positions outside 0..WIDTH-1 by the boundary mode.
    function automatic logic cell_at(input logic [WIDTH-1:0] s, input int j, input bmode_e m);
        int   p;
        logic use_pos;
        logic v;
        p       = j;
        use_pos = 1'b1;
        if ((j >= 0) && (j < WIDTH)) begin
            p = j;
        end else begin
            case (m)
                BM_WRAP:   p = (j < 0) ? (j + WIDTH) : (j - WIDTH);
                BM_MIRROR: p = (j < 0) ? (-j - 1) : (2*WIDTH - j - 1);
                default:   use_pos = 1'b0;
            endcase
        end
        if (use_pos) begin
            v = s[IDX_W'(p)];
        end else begin
            v = (m == BM_ONE);
        end
        return v;
    endfunction

    // Next generation: each cell looks up the rule with its neighbourhood, highest index as MSB.
    always_comb begin
        logic [NBR_W-1:0] nbr;
        nbr          = '0;
        next_state_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int k = 0; k < NBR_W; k++) begin
                nbr[k] = cell_at(state_q, i - RADIUS + k, bmode_q);
            end
            next_state_s[i] = rule_q[nbr];
        end
    end

    // Control FSM next-state and datapath updates.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rule_d  = rule_q;
        bmode_d = bmode_q;
        rem_d   = rem_q;
        gen_d   = gen_q;
        fixed_d = fixed_q;
        done_d  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (load_i) begin
                    state_d = load_data_i;
                    gen_d   = '0;
                    fixed_d = 1'b0;
                end else if (start_i) begin
                    if (steps_i != '0) begin
                        rule_d  = rule_i;
                        bmode_d = bmode_e'(bmode_i);
                        rem_d   = steps_i;
                        fixed_d = 1'b0;
                        fsm_d   = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    fsm_d = S_IDLE;
                end else if (next_state_s == state_q) begin
                    fixed_d = 1'b1;
                    done_d  = 1'b1;
                    fsm_d   = S_IDLE;
                end else begin
                    state_d = next_state_s;
                    gen_d   = (&gen_q) ? gen_q : (gen_q + STEP_W'(1));
                    rem_d   = rem_q - STEP_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        done_d = 1'b1;
                        fsm_d  = S_IDLE;
                    end else begin
                        fsm_d = S_RUN;
                    end
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
        busy_d = (fsm_d == S_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            state_q <= INIT;
            rule_q  <= '0;
            bmode_q <= BM_WRAP;
            rem_q   <= '0;
            gen_q   <= '0;
            done_q  <= 1'b0;
            fixed_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rule_q  <= rule_d;
            bmode_q <= bmode_d;
            rem_q   <= rem_d;
            gen_q   <= gen_d;
            done_q  <= done_d;
            fixed_q <= fixed_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fixed_pt_o  = fixed_q;
    assign gen_count_o = gen_q;
    assign state_o     = state_q;

endmodule
